// File: rtl/reg32_shift_sequencer.sv
// Command sequencer for a 32-bit shift register: load, rotate, serial-shift or read,
// then report the register contents together with a check against an internal shadow copy.
module reg32_shift_sequencer #(
    parameter int         WIDTH      = 32,
    parameter int         CNT_W      = 6,
    parameter logic [1:0] MODE_SHIFT = 2'b00,
    parameter logic [1:0] MODE_ROT   = 2'b01,
    parameter logic [1:0] MODE_LOAD  = 2'b10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_dir,
    input  logic             cmd_sin,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             enb,
    output logic             dir,
    output logic             s_in,
    output logic [1:0]       modo,
    output logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] q,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err
);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ROT   = 2'b01;
    localparam logic [1:0] OP_SHIFT = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_CAPTURE,
        ST_RESP
    } state_t;

    state_t state_reg, state_next;

    logic [1:0]       op_reg;
    logic             dir_reg;
    logic             sin_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] shadow_reg;
    logic [WIDTH-1:0] shadow_step;

    logic             enb_reg, enb_next;
    logic             dir_out_reg, dir_out_next;
    logic             s_in_reg, s_in_next;
    logic [1:0]       modo_reg, modo_next;
    logic [WIDTH-1:0] d_reg, d_next;
    logic             res_valid_reg, res_valid_next;
    logic [WIDTH-1:0] res_data_reg, res_data_next;
    logic             res_err_reg, res_err_next;

    logic accept;

    assign accept    = cmd_valid && (state_reg == ST_IDLE);
    assign cmd_ready = (state_reg == ST_IDLE);

    assign enb       = enb_reg;
    assign dir       = dir_out_reg;
    assign s_in      = s_in_reg;
    assign modo      = modo_reg;
    assign d         = d_reg;
    assign res_valid = res_valid_reg;
    assign res_data  = res_data_reg;
    assign res_err   = res_err_reg;

    // State register plus the registered register-side and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            enb_reg       <= 1'b0;
            dir_out_reg   <= 1'b0;
            s_in_reg      <= 1'b0;
            modo_reg      <= MODE_LOAD;
            d_reg         <= '0;
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            res_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            enb_reg       <= enb_next;
            dir_out_reg   <= dir_out_next;
            s_in_reg      <= s_in_next;
            modo_reg      <= modo_next;
            d_reg         <= d_next;
            res_valid_reg <= res_valid_next;
            res_data_reg  <= res_data_next;
            res_err_reg   <= res_err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = (cmd_op == OP_READ) ? ST_CAPTURE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if ((op_reg == OP_LOAD) || (cnt_reg == '0)) begin
                    state_next = ST_CAPTURE;
                end else begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: state_next = ST_RESP;
            ST_RESP: begin
                if (res_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs are computed from the upcoming state so the register sees them during that state.
    always_comb begin
        enb_next       = 1'b0;
        dir_out_next   = dir_out_reg;
        s_in_next      = s_in_reg;
        modo_next      = modo_reg;
        d_next         = d_reg;
        res_valid_next = (state_next == ST_RESP);
        res_data_next  = res_data_reg;
        res_err_next   = res_err_reg;
        case (state_next)
            ST_LOAD: begin
                enb_next  = 1'b1;
                modo_next = MODE_LOAD;
                d_next    = cmd_data;
            end
            ST_SHIFT: begin
                enb_next     = 1'b1;
                dir_out_next = dir_reg;
                s_in_next    = sin_reg;
                modo_next    = (op_reg == OP_ROT) ? MODE_ROT : MODE_SHIFT;
            end
            default: ;
        endcase
        if (state_reg == ST_CAPTURE) begin
            res_data_next = q;
            res_err_next  = (op_reg == OP_READ) ? 1'b0 : (q != shadow_reg);
        end
    end

    // Shadow copy advances exactly like the external register.
    always_comb begin
        shadow_step = shadow_reg;
        if (op_reg == OP_ROT) begin
            shadow_step = dir_reg ? {shadow_reg[0], shadow_reg[WIDTH-1:1]}
                                  : {shadow_reg[WIDTH-2:0], shadow_reg[WIDTH-1]};
        end else begin
            shadow_step = dir_reg ? {sin_reg, shadow_reg[WIDTH-1:1]}
                                  : {shadow_reg[WIDTH-2:0], sin_reg};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg     <= OP_LOAD;
            dir_reg    <= 1'b0;
            sin_reg    <= 1'b0;
            cnt_reg    <= '0;
            data_reg   <= '0;
            shadow_reg <= '0;
        end else begin
            if (accept) begin
                op_reg   <= cmd_op;
                dir_reg  <= cmd_dir;
                sin_reg  <= cmd_sin;
                cnt_reg  <= cmd_count;
                data_reg <= cmd_data;
            end
            if (state_reg == ST_LOAD) begin
                shadow_reg <= data_reg;
            end
            if (state_reg == ST_SHIFT) begin
                shadow_reg <= shadow_step;
                cnt_reg    <= cnt_reg - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_reg32_shift_sequencer.sv
// Bench for reg32_shift_sequencer: behavioural shift register on the register side,
// table-driven commands with a result scoreboard, plus backpressure, fault and reset cases.
module tb_reg32_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic        cmd_dir = 1'b0;
    logic        cmd_sin = 1'b0;
    logic [5:0]  cmd_count = '0;
    logic [31:0] cmd_data = '0;
    logic        enb;
    logic        dir;
    logic        s_in;
    logic [1:0]  modo;
    logic [31:0] d;
    logic [31:0] q;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [31:0] res_data;
    logic        res_err;

    reg32_shift_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dir(cmd_dir), .cmd_sin(cmd_sin), .cmd_count(cmd_count), .cmd_data(cmd_data),
        .enb(enb), .dir(dir), .s_in(s_in), .modo(modo), .d(d), .q(q),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err)
    );

    always #5 clk = ~clk;

    // Behavioural shift register, with an optional stuck-at-0 on bit 5 of its output.
    logic [31:0] reg_q = '0;
    logic        stuck5 = 1'b0;
    always @(posedge clk) begin
        if (enb) begin
            case (modo)
                2'b10: reg_q <= d;
                2'b01: reg_q <= dir ? {reg_q[0], reg_q[31:1]} : {reg_q[30:0], reg_q[31]};
                2'b00: reg_q <= dir ? {s_in, reg_q[31:1]} : {reg_q[30:0], s_in};
                default: ;
            endcase
        end
    end
    assign q = stuck5 ? (reg_q & 32'hFFFF_FFDF) : reg_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  op;
        logic        dir;
        logic        sin;
        logic [5:0]  cnt;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        int          exp_enb;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          enb;
        int          id;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_fail = 0;
    int accept_cyc = 0;
    int rv_cyc = 0;
    int enb_cnt = 0;
    bit rv_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: results are popped and compared at the response handshake.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            if (enb) enb_cnt++;
            if (res_valid && !rv_seen) begin
                rv_seen = 1;
                rv_cyc  = cyc;
            end
            if (res_valid && res_ready) begin
                mon_e = sb.pop_front();
                check($sformatf("txn%0d_data", mon_e.id), res_data, mon_e.data);
                check($sformatf("txn%0d_err", mon_e.id), res_err, mon_e.err);
                check($sformatf("txn%0d_latency", mon_e.id), rv_cyc - accept_cyc, mon_e.lat);
                check($sformatf("txn%0d_enb_cycles", mon_e.id), enb_cnt, mon_e.enb);
                $display("txn %0d: res_data=%h res_err=%b latency=%0d enb_cycles=%0d",
                         mon_e.id, res_data, res_err, rv_cyc - accept_cyc, enb_cnt);
            end
        end else if (res_valid) begin
            check("unexpected_res_valid", res_valid, 1'b0);
        end
    end

    task automatic send(input vec_t v, input int id);
        int guard;
        @(negedge clk);
        cmd_op    = v.op;
        cmd_dir   = v.dir;
        cmd_sin   = v.sin;
        cmd_count = v.cnt;
        cmd_data  = v.data;
        cmd_valid = 1'b1;
        guard = 0;
        while (!cmd_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) begin
            check($sformatf("txn%0d_accept_timeout", id), 32'd0, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        accept_cyc = cyc;
        enb_cnt    = 0;
        rv_seen    = 0;
        sb.push_back('{v.exp_data, v.exp_err, v.exp_lat, v.exp_enb, id});
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic drain(input int id);
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            check($sformatf("txn%0d_result_timeout", id), 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   guard;
        int   steps;
        bit   rv_high;
        logic [31:0] held;

        //          op     dir   sin   cnt     data           exp_data       err   lat enb
        vecs[0]  = '{2'b00, 1'b0, 1'b0, 6'd0,  32'h0000_0001, 32'h0000_0001, 1'b0, 3,  1};
        vecs[1]  = '{2'b01, 1'b0, 1'b0, 6'd1,  32'h0000_0001, 32'h0000_0002, 1'b0, 4,  2};
        vecs[2]  = '{2'b01, 1'b0, 1'b0, 6'd32, 32'h0000_0001, 32'h0000_0001, 1'b0, 35, 33};
        vecs[3]  = '{2'b10, 1'b1, 1'b1, 6'd4,  32'h0000_00F0, 32'hF000_000F, 1'b0, 7,  5};
        vecs[4]  = '{2'b01, 1'b0, 1'b0, 6'd0,  32'h1234_5678, 32'h1234_5678, 1'b0, 3,  1};
        vecs[5]  = '{2'b11, 1'b0, 1'b0, 6'd9,  32'hFFFF_0000, 32'h1234_5678, 1'b0, 2,  0};
        vecs[6]  = '{2'b10, 1'b0, 1'b1, 6'd40, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 1'b0, 43, 41};
        vecs[7]  = '{2'b10, 1'b0, 1'b0, 6'd3,  32'h8000_0001, 32'h0000_0008, 1'b0, 6,  4};
        vecs[8]  = '{2'b01, 1'b1, 1'b0, 6'd4,  32'h0000_000F, 32'hF000_0000, 1'b0, 7,  5};
        vecs[9]  = '{2'b10, 1'b1, 1'b0, 6'd35, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 38, 36};
        vecs[10] = '{2'b11, 1'b1, 1'b1, 6'd2,  32'h5555_5555, 32'h0000_0000, 1'b0, 2,  0};
        vecs[11] = '{2'b01, 1'b0, 1'b0, 6'd8,  32'hDEAD_BEEF, 32'hADBE_EFDE, 1'b0, 11, 9};

        // Reset values while reset is held.
        repeat (2) @(negedge clk);
        check("reset_enb", enb, 1'b0);
        check("reset_dir", dir, 1'b0);
        check("reset_s_in", s_in, 1'b0);
        check("reset_modo", modo, 2'b10);
        check("reset_d", d, 32'h0);
        check("reset_res_valid", res_valid, 1'b0);
        check("reset_res_data", res_data, 32'h0);
        check("reset_res_err", res_err, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 1'b1);

        for (int i = 0; i < 12; i++) begin
            send(vecs[i], i);
            drain(i);
        end

        // Stuck-at-0 on Q[5]: rotating 0x1 left by 5 lands on the dead bit.
        stuck5 = 1'b1;
        v = '{2'b01, 1'b0, 1'b0, 6'd5, 32'h0000_0001, 32'h0000_0000, 1'b1, 8, 6};
        send(v, 12);
        drain(12);
        stuck5 = 1'b0;

        // Result held under backpressure; a command offered meanwhile must be ignored.
        res_ready = 1'b0;
        v = '{2'b00, 1'b0, 1'b0, 6'd0, 32'h5A5A_0000, 32'h5A5A_0000, 1'b0, 3, 1};
        send(v, 13);
        guard = 0;
        while (!res_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("bp_res_valid_rise", res_valid, 1'b1);
        held = res_data;
        for (int k = 0; k < 10; k++) begin
            cmd_op    = 2'b00;
            cmd_data  = 32'h1111_1111;
            cmd_valid = 1'b1;
            @(negedge clk);
            check($sformatf("bp_hold%0d_res_valid", k), res_valid, 1'b1);
            check($sformatf("bp_hold%0d_res_data", k), res_data, held);
            check($sformatf("bp_hold%0d_cmd_ready", k), cmd_ready, 1'b0);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        drain(13);
        v = '{2'b11, 1'b0, 1'b0, 6'd0, 32'h0, 32'h5A5A_0000, 1'b0, 2, 0};
        send(v, 14);
        drain(14);

        // Reset during the third step of an 8-step shift aborts the command.
        v = '{2'b10, 1'b0, 1'b1, 6'd8, 32'h0000_FFFF, 32'h00FF_FFFF, 1'b0, 11, 9};
        send(v, 15);
        steps = 0;
        guard = 0;
        while (steps < 3 && guard < 50) begin
            @(negedge clk);
            if (enb && modo == 2'b00) steps++;
            guard++;
        end
        check("abort_reached_step3", steps, 3);
        #1 rst_n = 1'b0;
        sb.delete();
        #1;
        check("abort_enb_async", enb, 1'b0);
        check("abort_modo", modo, 2'b10);
        check("abort_res_valid", res_valid, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rv_high = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (res_valid) rv_high = 1;
        end
        check("abort_no_result", rv_high, 1'b0);
        check("abort_cmd_ready", cmd_ready, 1'b1);

        // Sequencer still works after the abort.
        send(vecs[1], 16);
        drain(16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
